// File: rtl/tt_mask_idx_rx.sv
// Receive side of the mask/index credit channel: buffers items and unpacks them into elements.
// Build option: define TT_MASK_IDX_RX_OVERFLOW_CHECK_EN to enable the sticky o_overflow_err flag.
module tt_mask_idx_rx #(
  parameter int DEPTH = 2,
  parameter int VLEN  = 256
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_mask_idx_valid,
  input  logic [64:0]               i_mask_idx_item,
  input  logic                      i_mask_idx_last_idx,
  output logic                      o_mask_idx_credit,
  input  logic                      i_is_indexed,
  input  logic [$clog2(VLEN+1)-1:0] i_vl,
  input  logic                      i_elem_req,
  output logic                      o_elem_valid,
  output logic                      o_elem_mask,
  output logic [63:0]               o_elem_index,
  output logic                      o_elem_last,
  input  logic                      i_flush,
  output logic                      o_overflow_err
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PCW = $clog2(DEPTH + 2);
  localparam int SW  = PCW + 1;
  localparam int VW  = $clog2(VLEN + 1);

  logic [65:0]    r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic [5:0]     r_bp;
  logic [VW-1:0]  r_ec;
  logic [PCW-1:0] r_pc;
  logic           r_credit;

  logic [65:0]    w_head;
  logic           w_full;
  logic           w_hs;
  logic           w_pop;
  logic           w_push;
  logic           w_strided_last;
  logic [SW-1:0]  w_add;
  logic [SW-1:0]  w_pc_sum;
  logic [PCW-1:0] w_pc_sat;
  logic [PW-1:0]  w_wptr_nxt;
  logic [PW-1:0]  w_rptr_nxt;

  assign w_head         = r_mem[r_rptr];
  assign w_full         = (r_count == CW'(DEPTH));
  assign w_strided_last = (r_ec == i_vl - VW'(1));

  always_comb begin
    o_elem_valid = (r_count != '0);
    o_elem_mask  = 1'b0;
    o_elem_index = '0;
    o_elem_last  = 1'b0;
    if (i_is_indexed) begin
      o_elem_mask  = w_head[64];
      o_elem_index = w_head[63:0];
      o_elem_last  = w_head[65];
    end else begin
      o_elem_mask  = w_head[r_bp];
      o_elem_last  = w_strided_last;
    end
  end

  assign w_hs   = o_elem_valid && i_elem_req;
  // strided words retire after their 64th element or at the end of the memop
  assign w_pop  = w_hs && (i_is_indexed || (r_bp == 6'd63) || w_strided_last);
  assign w_push = i_mask_idx_valid && (!w_full || w_pop);

  assign w_wptr_nxt = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
  assign w_rptr_nxt = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);

  always_comb begin
    w_add = '0;
    if (i_flush) w_add = SW'(r_count) + SW'(i_mask_idx_valid);
    else         w_add = SW'(w_pop);
    w_pc_sum = SW'(r_pc) + w_add;
    w_pc_sat = (w_pc_sum > SW'({PCW{1'b1}})) ? {PCW{1'b1}} : w_pc_sum[PCW-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_flush && w_push) r_mem[r_wptr] <= {i_mask_idx_last_idx, i_mask_idx_item};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_bp     <= '0;
      r_ec     <= '0;
      r_pc     <= '0;
      r_credit <= 1'b0;
    end else begin
      r_credit <= (w_pc_sat != '0);
      r_pc     <= w_pc_sat - PCW'(w_pc_sat != '0);
      if (i_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_bp    <= '0;
        r_ec    <= '0;
      end else begin
        if (w_push) r_wptr <= w_wptr_nxt;
        if (w_pop)  r_rptr <= w_rptr_nxt;
        if (w_push && !w_pop)      r_count <= r_count + CW'(1);
        else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        if (w_hs && !i_is_indexed) begin
          r_bp <= w_pop ? 6'd0 : r_bp + 6'd1;
          r_ec <= w_strided_last ? '0 : r_ec + VW'(1);
        end
      end
    end
  end

  assign o_mask_idx_credit = r_credit;

`ifdef TT_MASK_IDX_RX_OVERFLOW_CHECK_EN
  logic w_drop;
  logic r_ovf;
  assign w_drop = i_mask_idx_valid && w_full && !w_pop && !i_flush;
  always_ff @(posedge i_clk) begin
    if (i_reset)     r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end
  assign o_overflow_err = r_ovf;
`else
  assign o_overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_tt_mask_idx_rx.sv
// Bench for tt_mask_idx_rx: queue-based reference model, per-cycle compare, directed scenarios, random traffic.
module tb_tt_mask_idx_rx;
  localparam int DEPTH = 2;
  localparam int VLEN  = 256;
  localparam int VW    = $clog2(VLEN + 1);
  localparam int PCMAX = (1 << $clog2(DEPTH + 2)) - 1;
`ifdef TT_MASK_IDX_RX_OVERFLOW_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid = 1'b0;
  logic [64:0]   item = '0;
  logic          last_idx = 1'b0;
  logic          credit;
  logic          is_indexed = 1'b1;
  logic [VW-1:0] vl = '0;
  logic          elem_req = 1'b0;
  logic          e_valid, e_mask, e_last;
  logic [63:0]   e_index;
  logic          flush = 1'b0;
  logic          ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int cred_cnt = 0;
  bit chk_en = 1'b0;

  tt_mask_idx_rx #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_mask_idx_valid(valid), .i_mask_idx_item(item), .i_mask_idx_last_idx(last_idx),
    .o_mask_idx_credit(credit),
    .i_is_indexed(is_indexed), .i_vl(vl), .i_elem_req(elem_req),
    .o_elem_valid(e_valid), .o_elem_mask(e_mask), .o_elem_index(e_index), .o_elem_last(e_last),
    .i_flush(flush), .o_overflow_err(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: FIFO as a queue, element cursor as plain integers
  logic [65:0] mq[$];
  int m_bp = 0, m_ec = 0, m_pend = 0;
  bit m_credit = 1'b0, m_ovf = 1'b0;

  always @(posedge clk) begin : model
    int  sz, add;
    bit  hs, lst, pop;
    if (reset) begin
      mq.delete();
      m_bp = 0; m_ec = 0; m_pend = 0; m_credit = 1'b0; m_ovf = 1'b0;
    end else begin
      sz = mq.size(); add = 0; lst = 1'b0; pop = 1'b0;
      hs = (sz > 0) && elem_req;
      if (hs) begin
        if (is_indexed) pop = 1'b1;
        else begin
          lst = (m_ec == int'(vl) - 1);
          pop = lst || (m_bp == 63);
        end
      end
      if (flush) begin
        add = sz + int'(valid);
        mq.delete();
        m_bp = 0; m_ec = 0;
      end else begin
        if (hs && !is_indexed) begin
          m_bp = pop ? 0 : m_bp + 1;
          m_ec = lst ? 0 : m_ec + 1;
        end
        if (pop) begin
          void'(mq.pop_front());
          add = 1;
        end
        if (valid) begin
          if (sz < DEPTH || pop) mq.push_back({last_idx, item});
          else if (OVF_EN) m_ovf = 1'b1;
        end
      end
      m_pend = m_pend + add;
      if (m_pend > PCMAX) m_pend = PCMAX;
      m_credit = (m_pend > 0);
      if (m_credit) m_pend = m_pend - 1;
    end
  end

  always @(negedge clk) begin : compare
    logic [65:0] head;
    if (chk_en) begin
      chk("m_valid", e_valid, mq.size() > 0);
      chk("m_credit", credit, m_credit);
      chk("m_ovf", ovf, m_ovf);
      if (mq.size() > 0) begin
        head = mq[0];
        if (is_indexed) begin
          chk("m_mask", e_mask, head[64]);
          chk("m_index", e_index, head[63:0]);
          chk("m_last", e_last, head[65]);
        end else begin
          chk("m_mask", e_mask, head[m_bp]);
          chk("m_index", e_index, 64'd0);
          chk("m_last", e_last, m_ec == int'(vl) - 1);
        end
      end
    end
  end

  always @(negedge clk) if (credit === 1'b1) cred_cnt++;

  initial begin
    logic [63:0] word0;
    int c0, tx_cred;
    bit exp_m;

    repeat (3) tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", e_valid, 1'b0);
    chk("rst_credit", credit, 1'b0);
    chk("rst_ovf", ovf, 1'b0);

    // indexed, three items, consumer always ready; first push right as reset drops
    tick();
    reset = 1'b0;
    is_indexed = 1'b1; vl = VW'(3); elem_req = 1'b1;
    valid = 1'b1; item = {1'b1, 64'h10}; last_idx = 1'b0;
    tick();
    item = {1'b0, 64'h20};
    @(negedge clk);
    chk("idx0_valid", e_valid, 1'b1);
    chk("idx0_index", e_index, 64'h10);
    chk("idx0_mask", e_mask, 1'b1);
    chk("idx0_last", e_last, 1'b0);
    chk("idx0_credit", credit, 1'b0);
    tick();
    item = {1'b1, 64'h30}; last_idx = 1'b1;
    @(negedge clk);
    chk("idx1_index", e_index, 64'h20);
    chk("idx1_mask", e_mask, 1'b0);
    chk("idx1_credit", credit, 1'b1);
    tick();
    valid = 1'b0; last_idx = 1'b0;
    @(negedge clk);
    chk("idx2_index", e_index, 64'h30);
    chk("idx2_mask", e_mask, 1'b1);
    chk("idx2_last", e_last, 1'b1);
    chk("idx2_credit", credit, 1'b1);
    tick();
    @(negedge clk);
    chk("idx_empty", e_valid, 1'b0);
    chk("idx3_credit", credit, 1'b1);
    tick();
    @(negedge clk);
    chk("idx_credit_done", credit, 1'b0);
    tick();

    // strided, vl=70 over two words
    cred_cnt = 0;
    is_indexed = 1'b0; vl = VW'(70);
    word0 = 64'hF0F0_F0F0_F0F0_F0F0;
    valid = 1'b1; item = {1'b0, word0};
    tick();
    item = {1'b0, 64'h3}; last_idx = 1'b1;
    for (int e = 0; e < 70; e++) begin
      @(negedge clk);
      exp_m = (e < 64) ? word0[e] : (e < 66);
      chk("str_valid", e_valid, 1'b1);
      chk("str_mask", e_mask, exp_m);
      chk("str_last", e_last, e == 69);
      tick();
      valid = 1'b0; last_idx = 1'b0;
    end
    repeat (3) tick();
    chk("str_credits", cred_cnt, 2);
    chk("str_empty", e_valid, 1'b0);

    // full FIFO, push with same-cycle handshake
    is_indexed = 1'b1; elem_req = 1'b0;
    valid = 1'b1; item = {1'b1, 64'h100};
    tick();
    item = {1'b0, 64'h200};
    tick();
    valid = 1'b0;
    tick();
    valid = 1'b1; item = {1'b1, 64'h300}; elem_req = 1'b1;
    @(negedge clk);
    chk("full_head", e_index, 64'h100);
    tick();
    valid = 1'b0; elem_req = 1'b0;
    @(negedge clk);
    chk("full_head2", e_index, 64'h200);
    chk("full_ovf", ovf, 1'b0);
    elem_req = 1'b1;
    tick();
    @(negedge clk);
    chk("full_head3", e_index, 64'h300);
    tick();
    elem_req = 1'b0;
    @(negedge clk);
    chk("full_drained", e_valid, 1'b0);
    repeat (3) tick();

    // flush with two buffered plus a same-cycle push
    valid = 1'b1; item = {1'b0, 64'h400};
    tick();
    item = {1'b0, 64'h500};
    tick();
    item = {1'b0, 64'h600}; flush = 1'b1;
    tick();
    valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("fl_valid", e_valid, 1'b0);
    chk("fl_cr0", credit, 1'b1);
    tick();
    @(negedge clk);
    chk("fl_cr1", credit, 1'b1);
    tick();
    @(negedge clk);
    chk("fl_cr2", credit, 1'b1);
    tick();
    @(negedge clk);
    chk("fl_cr3", credit, 1'b0);
    tick();

    // push into a full FIFO without pop
    valid = 1'b1; item = {1'b1, 64'h700};
    tick();
    item = {1'b1, 64'h800};
    tick();
    item = {1'b1, 64'h900};
    tick();
    valid = 1'b0;
    @(negedge clk);
    chk("ovf_set", ovf, OVF_EN);
    chk("ovf_head", e_index, 64'h700);
    tick();
    tick();
    @(negedge clk);
    chk("ovf_hold", ovf, OVF_EN);

    // reset with credits pending and one entry buffered
    flush = 1'b1;
    tick();
    flush = 1'b0; valid = 1'b1; item = {1'b0, 64'hA00};
    tick();
    valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    c0 = cred_cnt;
    @(negedge clk);
    chk("rr_valid", e_valid, 1'b0);
    chk("rr_ovf", ovf, 1'b0);
    repeat (4) tick();
    chk("rr_no_credit", cred_cnt - c0, 0);

    // random traffic from a credit-respecting transmitter
    tx_cred = DEPTH;
    for (int seg = 0; seg < 8; seg++) begin
      flush = 1'b1; valid = 1'b0; elem_req = 1'b0;
      tick();
      flush = 1'b0;
      is_indexed = 1'($urandom % 2);
      vl = VW'($urandom_range(1, VLEN));
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (credit === 1'b1) tx_cred++;
        tick();
        valid = (tx_cred > 0) && ($urandom % 3 != 0);
        if (valid) tx_cred--;
        item = {1'($urandom % 2), $urandom(), $urandom()};
        last_idx = ($urandom % 4 == 0);
        elem_req = ($urandom % 4 != 0);
        flush = ($urandom % 64 == 0);
      end
      @(negedge clk);
      if (credit === 1'b1) tx_cred++;
      tick();
    end
    valid = 1'b0; flush = 1'b0; elem_req = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
